// File: rtl/column_streamer_if.sv
// Bundle of control, write and streaming signals between the column streamer
// and its producer/consumer. The master side drives requests and row data.
interface column_streamer_if #(
    parameter int IL = 154,
    parameter int OL = 48,
    parameter int CW = 6
);
    logic          iCLR;
    logic          iWE;
    logic [7:0]    iWSel;
    logic [OL-1:0] iWDATA;
    logic          iSTART;
    logic          iRDY;
    logic [IL-1:0] oDATA;
    logic          oVALID;
    logic [CW-1:0] oCOL;
    logic          oLAST;
    logic          oBUSY;
    logic          oDONE;

    modport master (
        output iCLR, iWE, iWSel, iWDATA, iSTART, iRDY,
        input  oDATA, oVALID, oCOL, oLAST, oBUSY, oDONE
    );

    modport slave (
        input  iCLR, iWE, iWSel, iWDATA, iSTART, iRDY,
        output oDATA, oVALID, oCOL, oLAST, oBUSY, oDONE
    );
endinterface

// File: rtl/column_streamer.sv
// Transposing serializer: rows of OL bits are written one per cycle, then the
// buffer is streamed column by column, bit k of every row presented in parallel.
module column_streamer #(
    parameter int IL = 154,
    parameter int OL = 48,
    parameter int CW = 6
) (
    input  logic             iCLK,
    input  logic             iRST,
    column_streamer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_COL = CW'(OL - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] col_reg, col_next;
    logic          write_en;
    logic          valid;
    logic [IL-1:0] column;

    // Writes are only honoured while idle so the buffer is frozen during a stream.
    assign write_en = (state_reg == IDLE) && bus.iWE && (32'(bus.iWSel) < IL);
    assign valid    = (state_reg == STREAM);

    generate
        for (genvar gi = 0; gi < IL; gi++) begin : g_row
            logic [OL-1:0] row_reg;
            logic          row_hit;

            assign row_hit = write_en && (bus.iWSel == 8'(gi));

            always_ff @(posedge iCLK or posedge iRST) begin
                if (iRST) begin
                    row_reg <= '0;
                end else if (bus.iCLR) begin
                    row_reg <= '0;
                end else if (row_hit) begin
                    row_reg <= bus.iWDATA;
                end
            end

            assign column[gi] = row_reg[col_reg];
        end
    endgenerate

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_reg <= IDLE;
            col_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        case (state_reg)
            IDLE: begin
                if (bus.iSTART) begin
                    state_next = STREAM;
                    col_next   = '0;
                end
            end
            STREAM: begin
                if (bus.iRDY) begin
                    if (col_reg == LAST_COL) begin
                        state_next = DONE;
                        col_next   = '0;
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                col_next   = '0;
            end
        endcase
        // Clear overrides everything except the asynchronous reset.
        if (bus.iCLR) begin
            state_next = IDLE;
            col_next   = '0;
        end
    end

    assign bus.oDATA  = valid ? column : '0;
    assign bus.oVALID = valid;
    assign bus.oCOL   = col_reg;
    assign bus.oLAST  = valid && (col_reg == LAST_COL);
    assign bus.oBUSY  = (state_reg != IDLE);
    assign bus.oDONE  = (state_reg == DONE);
endmodule

// File: tb/tb_column_streamer.sv
// Scoreboard bench for column_streamer: a row-array model predicts every streamed
// column; a negedge monitor pops and compares on each accepted transfer.
module tb_column_streamer;
    localparam int IL = 154;
    localparam int OL = 48;
    localparam int CW = 6;

    typedef struct {
        logic [IL-1:0] data;
        int            col;
    } exp_t;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [OL-1:0] model [IL];
    logic [OL-1:0] snap  [IL];
    logic [OL-1:0] rt    [IL];
    exp_t          exp_q [$];

    column_streamer_if #(.IL(IL), .OL(OL), .CW(CW)) bus ();

    column_streamer #(.IL(IL), .OL(OL), .CW(CW)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [IL-1:0] act, input logic [IL-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [IL-1:0] col_of(input int c);
        logic [IL-1:0] v;
        for (int i = 0; i < IL; i++) v[i] = snap[i][c];
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"},  bus.oDATA,  '0);
        check({tag, "_valid"}, IL'(bus.oVALID), '0);
        check({tag, "_col"},   IL'(bus.oCOL),   '0);
        check({tag, "_last"},  IL'(bus.oLAST),  '0);
        check({tag, "_busy"},  IL'(bus.oBUSY),  '0);
        check({tag, "_done"},  IL'(bus.oDONE),  '0);
    endtask

    // Monitor: every accepted transfer must match the head of the scoreboard.
    always @(negedge iCLK) begin
        if (!iRST) begin
            if (!bus.oVALID) begin
                check("data_zero_when_invalid", bus.oDATA, '0);
            end else if (bus.iRDY) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer", IL'(bus.oCOL), {IL{1'b1}});
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("xfer_col",  IL'(bus.oCOL),  IL'(e.col));
                    check("xfer_data", bus.oDATA,      e.data);
                    check("xfer_last", IL'(bus.oLAST), IL'(e.col == OL - 1));
                    for (int i = 0; i < IL; i++) rt[i][e.col] = bus.oDATA[i];
                end
            end
        end
    end

    task automatic write_row(input int r, input logic [OL-1:0] d);
        bus.iWE    = 1'b1;
        bus.iWSel  = 8'(r);
        bus.iWDATA = d;
        if (r < IL) model[r] = d;
        tick();
        bus.iWE = 1'b0;
    endtask

    function automatic logic [OL-1:0] rand_row();
        return {$urandom(), $urandom()};
    endfunction

    task automatic zero_model();
        for (int i = 0; i < IL; i++) model[i] = '0;
        exp_q.delete();
    endtask

    task automatic start_stream(input int wrow, input logic [OL-1:0] wd);
        exp_t e;
        if (wrow >= 0) begin
            bus.iWE    = 1'b1;
            bus.iWSel  = 8'(wrow);
            bus.iWDATA = wd;
            if (wrow < IL) model[wrow] = wd;
        end
        for (int i = 0; i < IL; i++) begin
            snap[i] = model[i];
            rt[i]   = ~model[i];
        end
        for (int c = 0; c < OL; c++) begin
            e.col  = c;
            e.data = col_of(c);
            exp_q.push_back(e);
        end
        bus.iSTART = 1'b1;
        tick();
        bus.iSTART = 1'b0;
        bus.iWE    = 1'b0;
    endtask

    // abort: 0 none, 1 clear at column 20, 2 async reset at column 10
    task automatic run_stream(input bit rand_rdy, input int stall_col, input int stall_len,
                              input bit ign, input int abort);
        int cyc = 1;
        int lows = 0;
        int stall_left = 0;
        bit stalled = 1'b0;
        bit rdy;
        int bad_rows = 0;
        while (cyc < 300) begin
            if (bus.oDONE) break;
            bus.iWE = 1'b0; bus.iSTART = 1'b0; bus.iCLR = 1'b0;
            rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bus.oVALID && int'(bus.oCOL) == stall_col && !stalled) begin
                stalled    = 1'b1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
                check("stall_col_hold",  IL'(bus.oCOL), IL'(stall_col));
                check("stall_data_hold", bus.oDATA, col_of(stall_col));
            end
            if (ign && bus.oCOL == 7) begin
                bus.iWE = 1'b1; bus.iWSel = 8'd0; bus.iWDATA = rand_row();
            end
            if (ign && bus.oCOL == 9) bus.iSTART = 1'b1;
            if (abort == 1 && bus.oCOL == 20) begin
                bus.iCLR = 1'b1;
                bus.iRDY = rdy;
                tick();
                bus.iCLR = 1'b0;
                check_idle_outputs("clr");
                zero_model();
                tick();
                check("clr_no_done", IL'(bus.oDONE), '0);
                return;
            end
            if (abort == 2 && bus.oCOL == 10) begin
                #2;
                iRST = 1'b1;
                #1;
                check_idle_outputs("async_rst");
                @(posedge iCLK);
                #1;
                iRST = 1'b0;
                zero_model();
                return;
            end
            bus.iRDY = rdy;
            if (!rdy) lows++;
            tick();
            cyc++;
        end
        bus.iWE = 1'b0; bus.iSTART = 1'b0;
        check("done_seen",  IL'(bus.oDONE), IL'(1));
        check("done_cycle", IL'(cyc), IL'(49 + lows));
        check("queue_drained", IL'(exp_q.size()), '0);
        exp_q.delete();
        for (int i = 0; i < IL; i++) if (rt[i] !== snap[i]) bad_rows++;
        check("round_trip_bad_rows", IL'(bad_rows), '0);
        tick();
        check("done_one_cycle", IL'(bus.oDONE), '0);
        check("idle_after_done", IL'(bus.oBUSY), '0);
    endtask

    initial begin
        bus.iCLR = 1'b0; bus.iWE = 1'b0; bus.iWSel = '0; bus.iWDATA = '0;
        bus.iSTART = 1'b0; bus.iRDY = 1'b1;
        for (int i = 0; i < IL; i++) model[i] = '0;
        #23;
        check_idle_outputs("reset");
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        tick();

        write_row(0,   48'h0000_0000_0001);
        write_row(153, 48'h8000_0000_0000);
        start_stream(-1, '0);
        run_stream(1'b0, -1, 0, 1'b0, 0);
        $display("[TB] directed transpose stream complete");

        for (int i = 0; i < IL; i++) write_row(i, rand_row());
        write_row(200, rand_row());
        start_stream(-1, '0);
        run_stream(1'b0, 5, 3, 1'b0, 0);
        $display("[TB] backpressure stream complete");

        start_stream(77, rand_row());
        run_stream(1'b1, -1, 0, 1'b1, 0);
        $display("[TB] ignored-input stream complete");

        start_stream(-1, '0);
        run_stream(1'b0, -1, 0, 1'b0, 1);
        start_stream(-1, '0);
        run_stream(1'b1, -1, 0, 1'b0, 0);
        $display("[TB] clear and zero stream complete");

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 20; j++) write_row($urandom_range(0, 255), rand_row());
            start_stream($urandom_range(0, IL - 1), rand_row());
            run_stream(1'b1, $urandom_range(0, OL - 1), $urandom_range(1, 4), 1'b0, 0);
            $display("[TB] random stream %0d complete", k);
        end

        start_stream(-1, '0);
        run_stream(1'b0, -1, 0, 1'b0, 2);
        tick();
        start_stream(-1, '0);
        run_stream(1'b0, -1, 0, 1'b0, 0);
        $display("[TB] post-reset zero stream complete");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/column_streamer.md
# column_streamer

Transposing serializer that feeds binarized feature maps back into the BWN/BNN compute array. Rows of OL bits are written one row per cycle from the previous layer's buffered results. On start, the block streams the buffer column by column: bit k of every row is presented in parallel, one column per accepted transfer. It is the read-side counterpart of the bit-collecting concatenation buffer, and streaming reproduces the original bit order, bit 0 first.

## Interface
Parameters:
- IL, 154, number of rows (channels); width of the streamed column
- OL, 48, bits per row; number of columns streamed
- CW, 6, column counter width; must satisfy 2^CW ≥ OL

Ports:
- iCLK  input  1  clock, rising edge
- iRST  input  1  reset, asynchronous, active-high
- iCLR  input  1  synchronous clear of buffer and control
- iWE  input  1  row write enable
- iWSel  input  8  row address, 0..IL-1
- iWDATA  input  OL  row data; bit 0 is streamed first
- iSTART  input  1  start streaming request
- iRDY  input  1  consumer ready
- oDATA  output  IL  current column, oDATA[i] = row i bit oCOL
- oVALID  output  1  oDATA holds a valid column
- oCOL  output  CW  index of the current column
- oLAST  output  1  current column is OL-1
- oBUSY  output  1  state is not IDLE
- oDONE  output  1  one-cycle pulse after the last column is accepted

## Operation
- Storage: IL × OL register array.
- States:
  - IDLE: accepts writes and iSTART.
  - STREAM: presents columns to the consumer.
  - DONE: lasts one cycle, drives oDONE=1, then returns to IDLE unconditionally.
- Writes:
  - In IDLE, iWE=1 with iWSel<IL writes iWDATA to that row at the clock edge.
  - iWSel≥IL is ignored; no row changes.
  - iWE in STREAM or DONE is ignored, so the buffer stays frozen while streaming.
- Start:
  - iSTART=1 in IDLE moves the state to STREAM and sets oCOL=0.
  - iSTART in STREAM or DONE is ignored.
  - iWE and iSTART in the same IDLE cycle: the write is performed and the written row is part of the stream.
- Handshake:
  - A transfer occurs on any cycle with oVALID && iRDY.
  - On a transfer with oCOL<OL-1, oCOL increments.
  - On a transfer with oCOL=OL-1, the state moves to DONE and oCOL returns to 0.
  - With iRDY=0, oDATA and oCOL hold.
- Outputs:
  - oVALID = (state==STREAM).
  - oLAST = oVALID && oCOL==OL-1.
  - oDATA is forced to 0 when oVALID=0; otherwise it is selected combinationally from the buffer by oCOL.
  - oBUSY = (state != IDLE).
- Priority, highest first: iRST, then iCLR, then the normal operation above.
- iCLR:
  - Zeroes every row, forces IDLE and oCOL=0.
  - Takes effect in any state, including mid-stream.
  - No oDONE pulse is generated.

## Timing
- Reset values: buffer all 0, state IDLE, oCOL=0, oDATA=0, oVALID=0, oLAST=0, oBUSY=0, oDONE=0.
- Write latency: a row written at edge N is visible to a stream started at edge N or later.
- Start latency: iSTART sampled at edge N gives oVALID=1 with column 0 after edge N.
- Throughput: one column per cycle while iRDY=1.
  - With iRDY held high, columns 0..47 occupy cycles N+1..N+48.
  - oDONE is high in cycle N+49.
  - IDLE resumes at N+50, the earliest cycle at which the next iSTART is accepted.
- Backpressure: each iRDY=0 cycle during STREAM extends the stream by exactly one cycle; no column is skipped or repeated.
- Asynchronous reset mid-stream clears all state and outputs immediately, without waiting for a clock edge.

## Test plan
- Reset: assert iRST mid-stream with oCOL=10 -> all outputs go to 0 asynchronously; a stream started afterward returns oDATA=0 for all 48 columns.
- Transpose, iRDY constant 1:
  - Stimulus: write row 0 = 48'h0000_0000_0001, row 153 = 48'h8000_0000_0000, then pulse iSTART.
  - Required: column 0 has oDATA[0]=1 only; column 47 has oDATA[153]=1 only with oLAST=1; oDONE pulses exactly 49 cycles after iSTART.
- Backpressure: drop iRDY for 3 cycles at oCOL=5 -> oCOL and oDATA hold at column 5; oDONE pulse arrives 3 cycles late; 48 transfers total.
- Ignored inputs:
  - Write with iWSel=200 -> no row changes.
  - iWE to row 0 during STREAM -> streamed data is unchanged.
  - iSTART during STREAM -> oCOL is not reset.
- iCLR: assert at oCOL=20 -> next cycle is IDLE with oVALID=0 and no oDONE; the next stream returns all zeros.
- Round trip: feed the streamed columns into the concatenation buffer with its enable tied to the transfer condition -> all 154 rows match the written data after 48 transfers.
